// File: rtl/i_fill_ctrl.sv
// i_fill_ctrl: instruction-cache miss fill engine.
// On a miss it waits a programmable delay. It then reads the 16-word block
// from word-wide backing memory, one word per cycle, and assembles it on WM.
// A one-cycle READY pulse marks the end of each completed fill.
module i_fill_ctrl #(
    parameter int LATENCY = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  A,
    input  logic         cache_hit,
    output logic [31:0]  mem_addr,
    input  logic [31:0]  mem_rdata,
    output logic [511:0] WM,
    output logic         READY,
    output logic         busy
);

    // WAIT lasts cnt_init+1 cycles, so that READY lands LATENCY edges after capture
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 17);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] base;
    logic [7:0]  cnt;
    logic [3:0]  k;
    logic [3:0]  k_next;
    logic        redirect;

    assign k_next   = k + 4'd1;
    assign redirect = (A[31:6] != base[31:6]);

    // Fill sequencer: miss capture, delay countdown, word burst and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= 32'd0;
            cnt      <= 8'd0;
            k        <= 4'd0;
            mem_addr <= 32'd0;
            WM       <= '0;
            READY    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cache_hit) begin
                        base     <= A & ~32'h0000_003F;
                        mem_addr <= A & ~32'h0000_003F;
                        cnt      <= CNT_INIT;
                        state    <= WAIT;
                        busy     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == 8'd0) begin
                        state    <= BURST;
                        k        <= 4'd0;
                        mem_addr <= base;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                BURST: begin
                    if (redirect) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        mem_addr <= base;
                    end else begin
                        WM[{k, 5'b00000} +: 32] <= mem_rdata;
                        k <= k_next;
                        if (k == 4'd15) begin
                            state    <= DONE;
                            READY    <= 1'b1;
                            mem_addr <= base;
                        end else begin
                            mem_addr <= {base[31:6], k_next, 2'b00};
                        end
                    end
                end
                DONE: begin
                    READY <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    READY <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
